adder_share_arbiter: RTL and testbench

Shares one 4-bit ripple-carry adder core between two requesters that each submit 8-bit additions. The block arbitrates round-robin and runs each accepted operation through the nibble adder in two passes, low nibble then high nibble with the carry held between them. It returns a 9-bit sum tagged with the requester ID through a valid/ready result port. It sits between the input-side request logic and the output/display path, so the small adder datapath can serve wider operands and multiple clients.

---
 rtl/adder_arb_pkg.sv | 16 +
 rtl/nibble_adder4.sv | 23 ++
 rtl/adder_share_arbiter.sv | 138 +++++++++++++
 tb/tb_adder_share_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared definitions for the nibble-serial shared adder: widths, FSM states, requester ID.
package adder_arb_pkg;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 2 * NIB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/nibble_adder4.sv
// Combinational ripple-carry adder: NIB-bit a + b + cin -> (NIB+1)-bit sum, carry in the MSB.
module nibble_adder4
  import adder_arb_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB:0]   sum
);

  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    for (int unsigned i = 0; i < NIB; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    sum[NIB] = c;
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Two-requester round-robin front end sharing one nibble adder; each 8-bit add runs
// low nibble then high nibble, and the 9-bit result is returned over a valid/ready port.
module adder_share_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W:0]   res_sum,
  output logic         res_id,
  output logic         busy
);

  import adder_arb_pkg::*;

  if (NREQ != 2 || W != 2 * NIB) begin : g_bad_cfg
    $error("adder_share_arbiter supports only NREQ=2 and W=2*NIB");
  end

  state_e         state_q,  state_d;
  logic           prio_q,   prio_d;
  logic [W-1:0]   op_a_q,   op_a_d;
  logic [W-1:0]   op_b_q,   op_b_d;
  req_id_t        id_q,     id_d;
  logic [NIB-1:0] sum_lo_q, sum_lo_d;
  logic           c_lo_q,   c_lo_d;
  logic [NIB:0]   sum_hi_q, sum_hi_d;

  logic           grant0, grant1, accept;
  logic [NIB-1:0] add_a, add_b;
  logic           add_cin;
  logic [NIB:0]   add_sum;

  // prio breaks ties only; a lone valid requester is always granted.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || !prio_q);
    grant1     = req1_valid && (!req0_valid ||  prio_q);
    req0_ready = (state_q == IDLE) && grant0;
    req1_ready = (state_q == IDLE) && grant1;
    accept     = req0_ready || req1_ready;
  end

  // The FSM state steers the single adder onto the low or high nibble pass.
  always_comb begin
    add_a   = op_a_q[NIB-1:0];
    add_b   = op_b_q[NIB-1:0];
    add_cin = 1'b0;
    if (state_q == HI) begin
      add_a   = op_a_q[W-1:NIB];
      add_b   = op_b_q[W-1:NIB];
      add_cin = c_lo_q;
    end
  end

  nibble_adder4 u_core (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum)
  );

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    id_d     = id_q;
    sum_lo_d = sum_lo_q;
    c_lo_d   = c_lo_q;
    sum_hi_d = sum_hi_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LO;
          id_d    = req1_ready;
          op_a_d  = req1_ready ? req1_a : req0_a;
          op_b_d  = req1_ready ? req1_b : req0_b;
          prio_d  = ~req1_ready;
        end
      end
      LO: begin
        sum_lo_d = add_sum[NIB-1:0];
        c_lo_d   = add_sum[NIB];
        state_d  = HI;
      end
      HI: begin
        sum_hi_d = add_sum;
        state_d  = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      id_q     <= 1'b0;
      sum_lo_q <= '0;
      c_lo_q   <= 1'b0;
      sum_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      id_q     <= id_d;
      sum_lo_q <= sum_lo_d;
      c_lo_q   <= c_lo_d;
      sum_hi_q <= sum_hi_d;
    end
  end

  always_comb begin
    res_valid = (state_q == DONE);
    res_sum   = {sum_hi_q, sum_lo_q};
    res_id    = id_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: single ops, alternation, backpressure, mid-op reset.
module tb_adder_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_a, req1_b;
  logic       res_valid, res_ready;
  logic [8:0] res_sum;
  logic       res_id;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.NREQ(2), .W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_id     (res_id),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic rdy(input bit id);
    return id ? req1_ready : req0_ready;
  endfunction

  // Starts just after a rising edge, ends just after a rising edge with the block idle.
  task automatic do_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                       input logic [8:0] exp);
    int n;
    int extra;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    res_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rdy(id) && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_eq("hs_ready", rdy(id), 1);
    check_eq("hs_other", rdy(!id), 0);
    n = 0;
    extra = 0;
    do begin
      @(negedge clk);
      n++;
      if (req0_ready || req1_ready) extra++;
    end while (!res_valid && n < 8);
    check_eq("latency", n, 3);
    check_eq("ready_once", extra, 0);
    check_eq("sum", res_sum, exp);
    check_eq("id", res_id, id);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("idle_valid", res_valid, 0);
    check_eq("idle_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, nres, both, cnt;
    logic [8:0] sums[4];
    logic       ids[4];
    int         times[4];

    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", res_valid, 0);
    check_eq("rst_sum", res_sum, 0);
    check_eq("rst_id", res_id, 0);
    check_eq("rst_rdy0", req0_ready, 0);
    check_eq("rst_rdy1", req1_ready, 0);
    check_eq("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(1'b0, 8'h0F, 8'h01, 9'h010);
    do_op(1'b1, 8'hFF, 8'hFF, 9'h1FE);
    do_op(1'b0, 8'h08, 8'h08, 9'h010);

    // Both requesters valid from reset: expect 0,1,0,1 every 4 cycles.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
    req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h80;
    res_ready = 1'b1;
    n = 0; nres = 0; both = 0;
    while (nres < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (req0_ready && req1_ready) both++;
      if (res_valid) begin
        ids[nres]   = res_id;
        sums[nres]  = res_sum;
        times[nres] = n;
        nres++;
      end
    end
    check_eq("alt_count", nres, 4);
    check_eq("alt_both_ready", both, 0);
    if (nres == 4) begin
      check_eq("alt_id0", ids[0], 0);
      check_eq("alt_id1", ids[1], 1);
      check_eq("alt_id2", ids[2], 0);
      check_eq("alt_id3", ids[3], 1);
      check_eq("alt_sum0", sums[0], 9'h046);
      check_eq("alt_sum1", sums[1], 9'h100);
      check_eq("alt_sum2", sums[2], 9'h046);
      check_eq("alt_sum3", sums[3], 9'h100);
      check_eq("alt_gap1", times[1] - times[0], 4);
      check_eq("alt_gap2", times[2] - times[1], 4);
      check_eq("alt_gap3", times[3] - times[2], 4);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure on a req1 result while req0 waits.
    rst = 1'b1;
    res_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h3C; req1_b = 8'h4D;
    n = 0;
    @(negedge clk);
    while (!req1_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_hs", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h21; req0_b = 8'h11;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_valid_rise", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check_eq("bp_valid", res_valid, 1);
      check_eq("bp_sum", res_sum, 9'h089);
      check_eq("bp_id", res_id, 1);
      check_eq("bp_rdy0", req0_ready, 0);
      check_eq("bp_rdy1", req1_ready, 0);
      check_eq("bp_busy", busy, 1);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("rel_valid", res_valid, 1);
    check_eq("done_no_accept", req0_ready, 0);
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check_eq("rel_valid_low", res_valid, 0);
    check_eq("rel_busy", busy, 0);
    check_eq("rel_rdy0", req0_ready, 1);

    // req0 accepted (prio -> 1), then reset lands during HI.
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("lo_busy", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("hi_busy", busy, 1);
    check_eq("hi_valid", res_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_hi_valid", res_valid, 0);
    check_eq("rst_hi_busy", busy, 0);
    check_eq("rst_hi_sum", res_sum, 0);
    check_eq("rst_hi_id", res_id, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    check_eq("no_ghost_result", cnt, 0);
    @(posedge clk); #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    check_eq("prio_rst_rdy0", req0_ready, 1);
    check_eq("prio_rst_rdy1", req1_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
